// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and parity modes.
// No logic; imported by uart_tx_fifo.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read and an occupancy count.
// Latency: a pushed word is visible at the head one edge after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign o_full     = (level_q == LVL_W'(DEPTH));
    assign o_empty    = (level_q == '0);
    assign o_level    = level_q;
    assign o_head_dat = mem_q[rd_ptr_q];

    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_push_dat;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: start, DATA_BITS LSB first, optional parity, stop bits.
// Latency: start bit on the line one edge after a write into an idle, empty transmitter.
// Backpressure: o_wready drops when full; writes while full are dropped and flag o_overflow.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DIV        = 139,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_BITS-1:0]          i_wdata,
    input  logic                          i_wvalid,
    output logic                          o_wready,
    input  logic                          i_ovf_clr,
    output logic                          o_txd,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       BIT_ONE = 4'd1;
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   txd_q, txd_d;
    logic                   ovf_q, ovf_d;

    logic [DATA_BITS-1:0]   head_dat;
    logic                   fifo_full, fifo_empty;
    logic                   pop, load, bit_done, par_bit;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (i_wvalid),
        .i_push_dat (i_wdata),
        .i_pop      (pop),
        .o_head_dat (head_dat),
        .o_level    (o_level),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    assign o_wready   = ~fifo_full;
    assign o_txd      = txd_q;
    assign o_overflow = ovf_q;
    assign o_busy     = (state_q != ST_IDLE) | ~fifo_empty;

    assign bit_done = (cnt_q == '0);
    assign par_bit  = (^head_dat) ^ (PARITY == PARITY_ODD);

    // A set on the same edge as a clear takes priority.
    always_comb begin
        ovf_d = ovf_q;
        if (i_ovf_clr)              ovf_d = 1'b0;
        if (i_wvalid && fifo_full)  ovf_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_done ? cnt_q : cnt_q - CNT_ONE;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        load    = 1'b0;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_TOP;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d = CNT_TOP;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            ST_PAR: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    cnt_d   = CNT_TOP;
                    bit_d   = '0;
                    txd_d   = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (bit_q != STOP_LAST) begin
                        bit_d = bit_q + BIT_ONE;
                        cnt_d = CNT_TOP;
                        txd_d = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Back-to-back frames: the head word is taken on the same edge the start bit begins.
        if (load) begin
            pop     = 1'b1;
            shift_d = head_dat;
            par_d   = par_bit;
            state_d = ST_START;
            cnt_d   = CNT_TOP;
            bit_d   = '0;
            txd_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
